// File: rtl/esp_uart_pkg.sv
// esp_uart_pkg: constants shared by the ESP32 UART transmit and receive paths.
// Holds the bit timing, the frame format (8N1) and the transmit FSM state encoding.
package esp_uart_pkg;

    // Clocks per bit. The receiver's 3-bit timing counter samples at count 4.
    localparam int unsigned CLKS_PER_BIT = 8;

    // Frame format: one start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits.
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Transmit FSM state encoding.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_STOP     = 3'd3;
    localparam logic [2:0] ST_BREAK    = 3'd4;
    localparam logic [2:0] ST_BRK_IDLE = 3'd5;

endpackage

// File: rtl/esp_uart_fifo.sv
// esp_uart_fifo: synchronous byte FIFO, depth 2**AW.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push_i     write request; accepted when not full, or when full and popping the same cycle
//   wdata_i    byte to write
//   pop_i      read request; ignored when empty
//   rdata_o    head entry (valid while not empty)
//   full_o     occupancy == depth
//   empty_o    occupancy == 0
//   count_o    occupancy 0..2**AW, registered
module esp_uart_fifo #(
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int unsigned Depth      = 2 ** AW;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem_q [Depth];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/esp_uart_tx.sv
// esp_uart_tx: 8N1 UART transmitter toward the ESP32, with TX FIFO, CTS flow control
// and break generation.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tx_data       byte to queue
//   tx_valid      write strobe; byte pushed on the edge where tx_valid && tx_ready
//   tx_ready      FIFO not full
//   tx_overflow   one-cycle pulse per write rejected because the FIFO was full
//   send_break    level request for a break
//   uart_cts_n    asynchronous active-low clear-to-send from the ESP32
//   uart_txd      registered serial output, idle high
//   busy          FSM not idle or FIFO non-empty
//   fifo_count    FIFO occupancy
module esp_uart_tx
    import esp_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = esp_uart_pkg::CLKS_PER_BIT,
    parameter int unsigned FIFO_AW      = 3,
    parameter int unsigned BREAK_BITS   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_overflow,
    input  logic               send_break,
    input  logic               uart_cts_n,
    output logic               uart_txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    // One down-counter times bits, stop bits and the break; sized for the longest.
    localparam int unsigned TW = $clog2(CLKS_PER_BIT * BREAK_BITS);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_RELOAD = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] BRK_RELOAD  = TW'(BREAK_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          break_req_q, break_req_d;
    logic          overflow_q, overflow_d;
    logic          cts_meta_q, cts_sync_q;

    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          launch;

    esp_uart_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // CTS synchronizer; resets to "not clear".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= uart_cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        launch   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch = 1'b1;
            end
            ST_START: begin
                if (timer_q == '0) begin
                    state_d = ST_DATA;
                    timer_d = BIT_RELOAD;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_RELOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        timer_d = STOP_RELOAD;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_STOP: begin
                // End of stop bit decides like IDLE so back-to-back frames have no gap.
                if (timer_q == '0) begin
                    launch = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_BREAK: begin
                // Timer parks at zero while the request is still held.
                if (timer_q == '0) begin
                    if (!send_break) begin
                        state_d = ST_BRK_IDLE;
                        timer_d = BIT_RELOAD;
                        txd_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_BRK_IDLE: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (launch) begin
            if (send_break || break_req_q) begin
                state_d = ST_BREAK;
                timer_d = BRK_RELOAD;
                txd_d   = 1'b0;
            end else if (!fifo_empty && !cts_sync_q) begin
                fifo_pop = 1'b1;
                shift_d  = fifo_rdata;
                state_d  = ST_START;
                timer_d  = BIT_RELOAD;
                txd_d    = 1'b0;
            end else begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        end

        // Remember a break request raised mid-frame, even a one-cycle pulse.
        break_req_d = break_req_q || (send_break && (state_q != ST_BREAK));
        if ((state_d == ST_BREAK) && (state_q != ST_BREAK)) begin
            break_req_d = 1'b0;
        end

        overflow_d = tx_valid && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            break_req_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            break_req_q <= break_req_d;
            overflow_q  <= overflow_d;
        end
    end

    assign uart_txd    = txd_q;
    assign tx_ready    = !fifo_full;
    assign tx_overflow = overflow_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
